// File: rtl/ctlb_assoc_if.sv
// rtl/ctlb_assoc_if.sv - lookup, fill and flush signal bundle for ctlb_assoc
interface ctlb_assoc_if #(
  parameter int WAYS       = 4,
  parameter int VA_WIDTH   = 65,
  parameter int DATA_WIDTH = 32,
  parameter int ASID_WIDTH = 21
);
  logic                  read_en;
  logic                  stall;
  logic [VA_WIDTH-1:0]   addr;
  logic [ASID_WIDTH-1:0] asid;
  logic                  read_hit;
  logic [WAYS-1:0]       read_hit_way;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  write_en;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_global;
  logic                  flush_req;
  logic                  flush_all;
  logic                  busy;

  modport master (
    output read_en, stall, addr, asid, write_en, write_data, write_global, flush_req, flush_all,
    input  read_hit, read_hit_way, read_data, busy
  );

  modport slave (
    input  read_en, stall, addr, asid, write_en, write_data, write_global, flush_req, flush_all,
    output read_hit, read_hit_way, read_data, busy
  );
endinterface

// File: rtl/ctlb_assoc.sv
// rtl/ctlb_assoc.sv - set-associative translation buffer with ASID/global match, LRU ages and flush sweep
module ctlb_assoc #(
  parameter int WAYS       = 4,
  parameter int SETS_LOG2  = 6,
  parameter int PAGE_SHIFT = 13,
  parameter int VA_WIDTH   = 65,
  parameter int DATA_WIDTH = 32,
  parameter int ASID_WIDTH = 21
) (
  input logic          clk,
  input logic          rst,
  ctlb_assoc_if.slave  bus
);
  localparam int SETS    = 1 << SETS_LOG2;
  localparam int AW      = $clog2(WAYS);
  localparam int TAG_LSB = PAGE_SHIFT + SETS_LOG2;
  localparam int TAG_W   = VA_WIDTH - TAG_LSB;

  typedef enum logic [1:0] {INIT, IDLE, FLUSH} state_t;

  state_t                 state;
  logic [SETS_LOG2-1:0]   count;
  logic                   flush_all_q;
  logic                   busy_q;
  logic                   hit_q;
  logic [WAYS-1:0]        hit_way_q;
  logic [DATA_WIDTH-1:0]  data_q;

  logic                   valid_mem [WAYS][SETS];
  logic                   glob_mem  [WAYS][SETS];
  logic [TAG_W-1:0]       tag_mem   [WAYS][SETS];
  logic [ASID_WIDTH-1:0]  asid_mem  [WAYS][SETS];
  logic [DATA_WIDTH-1:0]  data_mem  [WAYS][SETS];
  logic [AW-1:0]          age_mem   [WAYS][SETS];

  logic [SETS_LOG2-1:0]   idx;
  logic [TAG_W-1:0]       tag;
  logic [WAYS-1:0]        match;
  logic                   hit;
  logic [AW-1:0]          hit_idx;
  logic [AW-1:0]          victim_idx;
  logic [AW-1:0]          upd_way;
  logic [DATA_WIDTH-1:0]  hit_data;
  logic                   lookup_acc;
  logic                   fill_acc;
  logic                   lru_upd;
  logic [AW-1:0]          new_age [WAYS];
  logic                   unused_offset;

  assign idx           = bus.addr[TAG_LSB-1:PAGE_SHIFT];
  assign tag           = bus.addr[VA_WIDTH-1:TAG_LSB];
  assign unused_offset = ^bus.addr[PAGE_SHIFT-1:0];

  assign bus.read_hit     = hit_q;
  assign bus.read_hit_way = hit_way_q;
  assign bus.read_data    = data_q;
  assign bus.busy         = busy_q;

  // Lookup and fill share addr, so one match vector serves both; fill LRU wins over lookup LRU.
  always_comb begin
    match      = '0;
    hit_idx    = '0;
    victim_idx = '0;
    hit_data   = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid_mem[w][idx] && (tag_mem[w][idx] == tag) &&
                 (glob_mem[w][idx] || (asid_mem[w][idx] == bus.asid));
      if (match[w]) begin
        hit_idx  = AW'(w);
        hit_data = hit_data | data_mem[w][idx];
      end
      if (age_mem[w][idx] == '0) victim_idx = AW'(w);
    end
    hit        = |match;
    lookup_acc = bus.read_en && !bus.stall && !busy_q;
    fill_acc   = bus.write_en && !busy_q;
    upd_way    = (fill_acc && !hit) ? victim_idx : hit_idx;
    lru_upd    = fill_acc || (lookup_acc && hit);
    for (int w = 0; w < WAYS; w++) begin
      new_age[w] = age_mem[w][idx];
      if (AW'(w) == upd_way)
        new_age[w] = AW'(WAYS - 1);
      else if (age_mem[w][idx] > age_mem[upd_way][idx])
        new_age[w] = age_mem[w][idx] - AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= INIT;
      count       <= '0;
      busy_q      <= 1'b1;
      flush_all_q <= 1'b0;
      hit_q       <= 1'b0;
      hit_way_q   <= '0;
      data_q      <= '0;
    end else begin
      if (!bus.stall) begin
        hit_q     <= lookup_acc && hit;
        hit_way_q <= lookup_acc ? match : '0;
        data_q    <= lookup_acc ? hit_data : '0;
      end
      case (state)
        INIT: begin
          for (int w = 0; w < WAYS; w++) begin
            valid_mem[w][count] <= 1'b0;
            age_mem[w][count]   <= AW'(w);
          end
          count <= count + 1'b1;
          if (&count) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        IDLE: begin
          if (fill_acc) begin
            valid_mem[upd_way][idx] <= 1'b1;
            glob_mem[upd_way][idx]  <= bus.write_global;
            tag_mem[upd_way][idx]   <= tag;
            asid_mem[upd_way][idx]  <= bus.asid;
            data_mem[upd_way][idx]  <= bus.write_data;
          end
          if (lru_upd) begin
            for (int w = 0; w < WAYS; w++) age_mem[w][idx] <= new_age[w];
          end
          if (bus.flush_req) begin
            state       <= FLUSH;
            count       <= '0;
            flush_all_q <= bus.flush_all;
            busy_q      <= 1'b1;
          end
        end
        FLUSH: begin
          for (int w = 0; w < WAYS; w++) begin
            if (flush_all_q || !glob_mem[w][count]) valid_mem[w][count] <= 1'b0;
          end
          count <= count + 1'b1;
          if (&count) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= INIT;
          count  <= '0;
          busy_q <= 1'b1;
        end
      endcase
    end
  end
endmodule
